// File: rtl/ice51_mem_arb.sv
// Two-port arbiter in front of a single-port 512x8 memory with a 1-cycle registered read.
// Optional round-robin tie-breaking in IDLE is enabled by defining ICE51_MEM_ARB_RR_EN.
module ice51_mem_arb #(
    parameter int AW       = 9,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_a_req,
    input  logic          i_a_we,
    input  logic          i_a_lock,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_wdata,
    output logic          o_a_gnt,
    output logic          o_a_rvalid,
    output logic [DW-1:0] o_a_rdata,
    input  logic          i_b_req,
    input  logic          i_b_we,
    input  logic          i_b_lock,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_wdata,
    output logic          o_b_gnt,
    output logic          o_b_rvalid,
    output logic [DW-1:0] o_b_rdata,
    output logic          o_mem_we,
    output logic          o_mem_re,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic [1:0]    o_dbg_state
);

    // Handshake: a port holds req (and its command fields) stable until it sees gnt in the same cycle;
    // a granted read returns data with rvalid exactly one cycle later, writes return nothing.

    localparam int HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int HOLD_SAT = (MAX_HOLD > 0) ? MAX_HOLD : (2 ** HW - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOCK_A = 2'd1;
    localparam logic [1:0] S_LOCK_B = 2'd2;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    logic [1:0]    state, state_nxt;
    logic          last_owner;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          ovr_vld, ovr_vld_nxt;
    logic          ovr_port, ovr_port_nxt;
    logic          a_gnt, b_gnt;
    logic          tie_winner;
    logic          hold_at_max;
    logic          hold_can_inc;

    assign hold_at_max  = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));
    assign hold_can_inc = (hold_cnt != HW'(HOLD_SAT));

    always_comb begin
        if (ovr_vld) begin
            tie_winner = ovr_port;
        end else begin
`ifdef ICE51_MEM_ARB_RR_EN
            tie_winner = ~last_owner;
`else
            tie_winner = OWN_A;
`endif
        end
    end

    always_comb begin
        a_gnt        = 1'b0;
        b_gnt        = 1'b0;
        state_nxt    = state;
        hold_nxt     = hold_cnt;
        ovr_vld_nxt  = ovr_vld;
        ovr_port_nxt = ovr_port;
        case (state)
            S_LOCK_A: begin
                if (i_a_req && !(hold_at_max && i_b_req)) begin
                    a_gnt = 1'b1;
                    if (!i_a_lock) begin
                        state_nxt = S_IDLE;
                        hold_nxt  = '0;
                    end else if (hold_can_inc) begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end else begin
                    // Either A let go, or B has waited out the hold budget and gets the next slot.
                    state_nxt = S_IDLE;
                    hold_nxt  = '0;
                    if (i_a_req) begin
                        ovr_vld_nxt  = 1'b1;
                        ovr_port_nxt = OWN_B;
                    end
                end
            end
            S_LOCK_B: begin
                if (i_b_req && !(hold_at_max && i_a_req)) begin
                    b_gnt = 1'b1;
                    if (!i_b_lock) begin
                        state_nxt = S_IDLE;
                        hold_nxt  = '0;
                    end else if (hold_can_inc) begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end else begin
                    state_nxt = S_IDLE;
                    hold_nxt  = '0;
                    if (i_b_req) begin
                        ovr_vld_nxt  = 1'b1;
                        ovr_port_nxt = OWN_A;
                    end
                end
            end
            default: begin
                ovr_vld_nxt = 1'b0;
                if (i_a_req && i_b_req) begin
                    a_gnt = (tie_winner == OWN_A);
                    b_gnt = (tie_winner == OWN_B);
                end else begin
                    a_gnt = i_a_req;
                    b_gnt = i_b_req;
                end
                if (a_gnt && i_a_lock) begin
                    state_nxt = S_LOCK_A;
                    hold_nxt  = HW'(1);
                end else if (b_gnt && i_b_lock) begin
                    state_nxt = S_LOCK_B;
                    hold_nxt  = HW'(1);
                end
            end
        endcase
        if (!i_nrst) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
        end
    end

    assign o_a_gnt     = a_gnt;
    assign o_b_gnt     = b_gnt;
    assign o_mem_we    = (a_gnt & i_a_we) | (b_gnt & i_b_we);
    assign o_mem_re    = (a_gnt & ~i_a_we) | (b_gnt & ~i_b_we);
    assign o_mem_addr  = a_gnt ? i_a_addr : (b_gnt ? i_b_addr : '0);
    assign o_mem_wdata = a_gnt ? i_a_wdata : (b_gnt ? i_b_wdata : '0);
    assign o_a_rdata   = i_mem_rdata;
    assign o_b_rdata   = i_mem_rdata;
    assign o_dbg_state = state;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state      <= S_IDLE;
            last_owner <= OWN_B;
            hold_cnt   <= '0;
            ovr_vld    <= 1'b0;
            ovr_port   <= OWN_A;
            o_a_rvalid <= 1'b0;
            o_b_rvalid <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            ovr_vld  <= ovr_vld_nxt;
            ovr_port <= ovr_port_nxt;
            if (a_gnt) begin
                last_owner <= OWN_A;
            end else if (b_gnt) begin
                last_owner <= OWN_B;
            end
            o_a_rvalid <= a_gnt & ~i_a_we;
            o_b_rvalid <= b_gnt & ~i_b_we;
        end
    end

endmodule

// File: tb/tb_ice51_mem_arb.sv
// Self-checking bench for ice51_mem_arb: behavioural 512x8 memory, directed scenarios plus random
// single-port traffic, read data checked through per-port expected queues.
module tb_ice51_mem_arb;

    localparam int AW       = 9;
    localparam int DW       = 8;
    localparam int MAX_HOLD = 4;
`ifdef ICE51_MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nrst;
    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    dbg_state;

    logic [DW-1:0] mem [0:511];
    logic [DW-1:0] ref_mem [0:511];
    logic [DW-1:0] exp_q_a[$];
    logic [DW-1:0] exp_q_b[$];
    logic          pend_a = 1'b0;
    logic          pend_b = 1'b0;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    ice51_mem_arb #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk(clk), .i_nrst(nrst),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_lock(a_lock), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdata(a_rdata),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_lock(b_lock), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdata(b_rdata),
        .o_mem_we(mem_we), .o_mem_re(mem_re), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_dbg_state(dbg_state)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; checks last cycle's read return, then this cycle's grant and memory command.
    task automatic step(input logic ar, input logic awe, input logic alk, input logic [AW-1:0] aad,
                        input logic [DW-1:0] awd, input logic br, input logic bwe, input logic blk,
                        input logic [AW-1:0] bad, input logic [DW-1:0] bwd,
                        input logic eg_a, input logic eg_b, input logic rst_after);
        logic [DW-1:0] e;
        a_req = ar; a_we = awe; a_lock = alk; a_addr = aad; a_wdata = awd;
        b_req = br; b_we = bwe; b_lock = blk; b_addr = bad; b_wdata = bwd;
        @(negedge clk);
        check("a_rvalid", a_rvalid, pend_a);
        check("b_rvalid", b_rvalid, pend_b);
        if (pend_a && exp_q_a.size() > 0) begin
            e = exp_q_a.pop_front();
            check("a_rdata", a_rdata, e);
        end
        if (pend_b && exp_q_b.size() > 0) begin
            e = exp_q_b.pop_front();
            check("b_rdata", b_rdata, e);
        end
        check("a_gnt", a_gnt, eg_a);
        check("b_gnt", b_gnt, eg_b);
        check("mem_we", mem_we, (eg_a & awe) | (eg_b & bwe));
        check("mem_re", mem_re, (eg_a & ~awe) | (eg_b & ~bwe));
        if (eg_a) check("mem_addr_a", mem_addr, aad);
        if (eg_b) check("mem_addr_b", mem_addr, bad);
        pend_a = eg_a & ~awe;
        pend_b = eg_b & ~bwe;
        if (pend_a) exp_q_a.push_back(ref_mem[aad]);
        if (pend_b) exp_q_b.push_back(ref_mem[bad]);
        if (eg_a && awe) ref_mem[aad] = awd;
        if (eg_b && bwe) ref_mem[bad] = bwd;
        if (rst_after) begin
            nrst = 1'b0;
            pend_a = 1'b0;
            pend_b = 1'b0;
            exp_q_a.delete();
            exp_q_b.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 0, 0, 0);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          p, w;
        logic [AW-1:0] ad;
        for (int i = 0; i < 512; i++) begin
            d = DW'($urandom_range(0, 255));
            mem[i] <= d;
            ref_mem[i] = d;
        end
        mem[9'h010] <= 8'h5A;
        ref_mem[9'h010] = 8'h5A;

        nrst = 1'b0;
        a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 9'h010, 0, 1, 1, 0, 9'h011, 8'h11, 0, 0, 0);
        check("reset_state", dbg_state, 2'd0);
        step(1, 1, 1, 9'h012, 8'h22, 1, 0, 1, 9'h013, 0, 0, 0, 0);
        nrst = 1'b1;

        // Tie for four cycles: fixed priority keeps A, round-robin alternates starting with A.
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 9'h020, 0, 1, 0, 0, 9'h030, 0, RR ? (i % 2 == 0) : 1'b1, RR ? (i % 2 == 1) : 1'b0, 0);
        idle_step();

        // Single A read.
        step(1, 0, 0, 9'h010, 0, 0, 0, 0, '0, 0, 1, 0, 0);
        idle_step();

        // B locked burst while A waits; A served once B releases.
        step(0, 0, 0, '0, 0, 1, 1, 1, 9'h1FF, 8'hC3, 0, 1, 0);
        step(1, 0, 0, 9'h1FF, 0, 1, 1, 1, 9'h1FF, 8'hC3, 0, 1, 0);
        step(1, 0, 0, 9'h1FF, 0, 1, 1, 1, 9'h1FF, 8'hC3, 0, 1, 0);
        step(1, 0, 0, 9'h1FF, 0, 1, 1, 0, 9'h1FF, 8'hC3, 0, 1, 0);
        step(1, 0, 0, 9'h1FF, 0, 0, 0, 0, '0, 0, 1, 0, 0);
        idle_step();

        // A holds the lock; B waits out MAX_HOLD grants, gets one slot, then A resumes.
        step(1, 0, 1, 9'h040, 0, 0, 0, 0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            step(1, 0, 1, 9'h041, 0, 1, 0, 0, 9'h050, 0, 1, 0, 0);
        step(1, 0, 1, 9'h042, 0, 1, 0, 0, 9'h050, 0, 0, 0, 0);
        step(1, 0, 1, 9'h042, 0, 1, 0, 0, 9'h050, 0, 0, 1, 0);
        step(1, 0, 1, 9'h042, 0, 0, 0, 0, '0, 0, 1, 0, 0);
        step(1, 0, 0, 9'h043, 0, 0, 0, 0, '0, 0, 1, 0, 0);
        idle_step();

        // Write then read the same address back to back.
        d = DW'($urandom_range(0, 255));
        step(1, 1, 0, 9'h0AB, d, 0, 0, 0, '0, 0, 1, 0, 0);
        step(1, 0, 0, 9'h0AB, 0, 0, 0, 0, '0, 0, 1, 0, 0);
        idle_step();

        // Reset lands on the edge right after a B read grant.
        step(0, 0, 0, '0, 0, 1, 0, 0, 9'h030, 0, 0, 1, 1);
        step(1, 0, 0, 9'h020, 0, 1, 0, 0, 9'h030, 0, 0, 0, 0);
        nrst = 1'b1;
        step(1, 0, 0, 9'h020, 0, 1, 0, 0, 9'h030, 0, 1, 0, 0);
        step(0, 0, 0, '0, 0, 1, 0, 0, 9'h030, 0, 0, 1, 0);
        idle_step();

        // Random single-requester traffic.
        for (int i = 0; i < 24; i++) begin
            p  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            ad = AW'($urandom_range(0, 511));
            d  = DW'($urandom_range(0, 255));
            if (p) step(0, 0, 0, '0, 0, 1, w, 0, ad, d, 0, 1, 0);
            else   step(1, w, 0, ad, d, 0, 0, 0, '0, 0, 1, 0, 0);
        end
        idle_step();

        check("a_queue_empty", exp_q_a.size(), 0);
        check("b_queue_empty", exp_q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
